// File: rtl/sru_signal_observe_unit_if.sv
// Bundles the observe unit's config, trigger handshake and status signals.
interface sru_signal_observe_unit_if #(
  parameter int unsigned HIST_W = 4,
  parameter int unsigned CNT_W  = 8
);
  logic              Qin;
  logic              CfgValid;
  logic              CfgReady;
  logic [HIST_W-1:0] CfgPattern;
  logic [HIST_W-1:0] CfgMask;
  logic [CNT_W-1:0]  CfgThreshold;
  logic              ArmEn;
  logic              TrigOut;
  logic              TrigAck;
  logic [CNT_W-1:0]  MatchCnt;
  logic              Busy;

  // PLA / controller side
  modport master (
    output Qin, CfgValid, CfgPattern, CfgMask, CfgThreshold, ArmEn, TrigAck,
    input  CfgReady, TrigOut, MatchCnt, Busy
  );

  // Observe unit side
  modport slave (
    input  Qin, CfgValid, CfgPattern, CfgMask, CfgThreshold, ArmEn, TrigAck,
    output CfgReady, TrigOut, MatchCnt, Busy
  );
endinterface

// File: rtl/sru_signal_observe_unit.sv
// Signal observe unit: counts masked pattern matches on a serial signal and
// raises a held trigger to the PLA once the programmed count is reached.
module sru_signal_observe_unit #(
  parameter int unsigned HIST_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input logic clk,
  input logic rst,
  sru_signal_observe_unit_if.slave bus
);

  localparam int unsigned FILL_W = $clog2(HIST_W + 1);

  typedef enum logic [1:0] {IDLE, ARMED, TRIGGERED} state_t;

  state_t            state, state_next;
  logic [HIST_W-1:0] hist;
  logic [HIST_W-1:0] pattern, pattern_next;
  logic [HIST_W-1:0] mask, mask_next;
  logic [CNT_W-1:0]  thr, thr_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [FILL_W-1:0] fill, fill_next;
  logic              trig, trig_next;
  logic              cfg_ready, busy;
  logic [CNT_W-1:0]  thr_eff;
  logic [CNT_W:0]    cnt_inc;
  logic              fill_full;
  logic              match;

  // A zero threshold behaves like one; the increment keeps a carry bit for saturation
  assign thr_eff   = (thr == '0) ? CNT_W'(1) : thr;
  assign cnt_inc   = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign fill_full = (fill == FILL_W'(HIST_W));
  assign match     = (state == ARMED) && fill_full && (mask != '0)
                     && (((hist ^ pattern) & mask) == '0);

  assign bus.CfgReady = cfg_ready;
  assign bus.Busy     = busy;
  assign bus.TrigOut  = trig;
  assign bus.MatchCnt = cnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, counters, config capture and trigger
  always_comb begin
    state_next   = state;
    pattern_next = pattern;
    mask_next    = mask;
    thr_next     = thr;
    cnt_next     = cnt;
    fill_next    = fill;
    trig_next    = trig;
    case (state)
      IDLE: begin
        fill_next = '0;
        if (bus.CfgValid) begin
          pattern_next = bus.CfgPattern;
          mask_next    = bus.CfgMask;
          thr_next     = bus.CfgThreshold;
        end
        if (bus.ArmEn) begin
          state_next = ARMED;
          cnt_next   = '0;
        end
      end
      ARMED: begin
        if (!fill_full) fill_next = fill + FILL_W'(1);
        if (!bus.ArmEn) begin
          state_next = IDLE;
          cnt_next   = '0;
          fill_next  = '0;
        end else if (match) begin
          cnt_next = cnt_inc[CNT_W] ? cnt : cnt_inc[CNT_W-1:0];
          if (cnt_inc >= {1'b0, thr_eff}) begin
            state_next = TRIGGERED;
            trig_next  = 1'b1;
          end
        end
      end
      TRIGGERED: begin
        if (!fill_full) fill_next = fill + FILL_W'(1);
        if (bus.TrigAck) begin
          trig_next  = 1'b0;
          cnt_next   = '0;
          fill_next  = '0;
          state_next = bus.ArmEn ? ARMED : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      pattern   <= '0;
      mask      <= '0;
      thr       <= CNT_W'(1);
      cnt       <= '0;
      fill      <= '0;
      trig      <= 1'b0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      hist      <= {hist[HIST_W-2:0], bus.Qin};
      pattern   <= pattern_next;
      mask      <= mask_next;
      thr       <= thr_next;
      cnt       <= cnt_next;
      fill      <= fill_next;
      trig      <= trig_next;
      cfg_ready <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_sru_signal_observe_unit.sv
// Bench for the signal observe unit: directed scenarios plus a random phase,
// every cycle compared against a sample-list reference model.
module tb_sru_signal_observe_unit;
  localparam int unsigned HIST_W = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  // Reference model: observable state kept as plain ints and a list of samples
  int              m_mode;  // 0 idle, 1 armed, 2 triggered
  bit              m_samples[$];
  int              m_cnt;
  bit              m_trig;
  bit [HIST_W-1:0] m_pat;
  bit [HIST_W-1:0] m_mask;
  int              m_thr;

  sru_signal_observe_unit_if #(.HIST_W(HIST_W), .CNT_W(CNT_W)) bus ();

  sru_signal_observe_unit #(.HIST_W(HIST_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Last HIST_W samples since arming compared bit by bit; newest sample is bit 0
  function automatic bit model_match();
    int n;
    n = m_samples.size();
    if (m_mode != 1 || n < HIST_W || m_mask == '0) return 1'b0;
    for (int i = 0; i < HIST_W; i++)
      if (m_mask[i] && (m_samples[n-1-i] != m_pat[i])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update();
    bit hit;
    int need;
    if (rst) begin
      m_mode = 0; m_samples.delete(); m_cnt = 0; m_trig = 0;
      m_pat = '0; m_mask = '0; m_thr = 1;
      return;
    end
    hit = model_match();
    case (m_mode)
      0: begin
        if (bus.CfgValid) begin
          m_pat = bus.CfgPattern; m_mask = bus.CfgMask; m_thr = int'(bus.CfgThreshold);
        end
        if (bus.ArmEn) begin
          m_mode = 1; m_cnt = 0; m_samples.delete();
        end
      end
      1: begin
        m_samples.push_back(bus.Qin);
        if (!bus.ArmEn) begin
          m_mode = 0; m_cnt = 0; m_samples.delete();
        end else if (hit) begin
          m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
          need  = (m_thr == 0) ? 1 : m_thr;
          if (m_cnt >= need) begin
            m_mode = 2; m_trig = 1;
          end
        end
      end
      default: begin
        m_samples.push_back(bus.Qin);
        if (bus.TrigAck) begin
          m_trig = 0; m_cnt = 0; m_samples.delete();
          m_mode = bus.ArmEn ? 1 : 0;
        end
      end
    endcase
    if (m_samples.size() > HIST_W) void'(m_samples.pop_front());
  endtask

  task automatic check_all();
    check("trig", 32'(bus.TrigOut), 32'(m_trig));
    check("cnt", 32'(bus.MatchCnt), 32'(m_cnt));
    check("ready", 32'(bus.CfgReady), 32'(m_mode == 0));
    check("busy", 32'(bus.Busy), 32'(m_mode != 0));
  endtask

  // One clock edge: update the model with the applied inputs, then compare
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic configure(input logic [HIST_W-1:0] pat, input logic [HIST_W-1:0] msk,
                           input logic [CNT_W-1:0] thr);
    bus.CfgValid = 1'b1; bus.CfgPattern = pat; bus.CfgMask = msk; bus.CfgThreshold = thr;
    tick();
    bus.CfgValid = 1'b0;
  endtask

  // Ticks until TrigOut rises or the budget runs out; returns edges taken
  task automatic run_to_trigger(input int budget, output int n);
    n = 0;
    while (!bus.TrigOut && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.Qin = 1'b0; bus.CfgValid = 1'b0; bus.CfgPattern = '0; bus.CfgMask = '0;
    bus.CfgThreshold = '0; bus.ArmEn = 1'b0; bus.TrigAck = 1'b0;
    tick(); tick();
    check("reset_trig", 32'(bus.TrigOut), 32'd0);
    check("reset_ready", 32'(bus.CfgReady), 32'd1);
    rst = 1'b0;

    // Default mask is zero: toggling input never matches
    bus.ArmEn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.Qin = 1'(i & 1);
      tick();
    end
    check("t1_trig", 32'(bus.TrigOut), 32'd0);
    check("t1_cnt", 32'(bus.MatchCnt), 32'd0);
    bus.ArmEn = 1'b0;
    tick();

    // Exact pattern 0110 with threshold 1
    configure(4'b0110, 4'b1111, 8'd1);
    bus.ArmEn = 1'b1; bus.Qin = 1'($urandom); tick();
    bus.Qin = 1'b0; tick();
    bus.Qin = 1'b1; tick();
    bus.Qin = 1'b1; tick();
    bus.Qin = 1'b0; tick();
    check("t2_trig_early", 32'(bus.TrigOut), 32'd0);
    tick();
    check("t2_trig", 32'(bus.TrigOut), 32'd1);
    check("t2_cnt", 32'(bus.MatchCnt), 32'd1);
    check("t2_ready", 32'(bus.CfgReady), 32'd0);
    bus.TrigAck = 1'b1; bus.ArmEn = 1'b0; tick();
    bus.TrigAck = 1'b0;

    // Partial mask, threshold 3, input held high; re-arm through acknowledge
    configure(4'b1111, 4'b0011, 8'd3);
    bus.Qin = 1'b1; bus.ArmEn = 1'b1; tick();
    run_to_trigger(20, n);
    check("t3_latency", 32'(n), 32'd7);
    check("t3_cnt", 32'(bus.MatchCnt), 32'd3);
    bus.TrigAck = 1'b1; tick();
    bus.TrigAck = 1'b0;
    check("t3_rearm_cnt", 32'(bus.MatchCnt), 32'd0);
    check("t3_rearm_busy", 32'(bus.Busy), 32'd1);
    run_to_trigger(20, n);
    check("t3_rearm_latency", 32'(n), 32'd7);

    // Dropping ArmEn while triggered keeps TrigOut until acknowledged
    bus.ArmEn = 1'b0;
    tick(); tick(); tick();
    check("t4_hold", 32'(bus.TrigOut), 32'd1);
    bus.TrigAck = 1'b1; tick();
    bus.TrigAck = 1'b0;
    check("t4_trig", 32'(bus.TrigOut), 32'd0);
    check("t4_ready", 32'(bus.CfgReady), 32'd1);

    // Config while armed is ignored; reset clears a pending trigger
    bus.ArmEn = 1'b1; tick();
    configure(4'b0000, 4'b0001, 8'd1);
    run_to_trigger(20, n);
    check("t5_cnt", 32'(bus.MatchCnt), 32'd3);
    check("t5_latency", 32'(n), 32'd6);
    bus.ArmEn = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    check("t5_rst_trig", 32'(bus.TrigOut), 32'd0);
    check("t5_rst_cnt", 32'(bus.MatchCnt), 32'd0);
    check("t5_rst_ready", 32'(bus.CfgReady), 32'd1);

    // Zero threshold acts as one
    configure(4'b0001, 4'b0001, 8'd0);
    bus.Qin = 1'b1; bus.ArmEn = 1'b1; tick();
    run_to_trigger(20, n);
    check("t6_thr0_latency", 32'(n), 32'd5);
    check("t6_thr0_cnt", 32'(bus.MatchCnt), 32'd1);
    bus.TrigAck = 1'b1; bus.ArmEn = 1'b0; tick();
    bus.TrigAck = 1'b0;

    // Full-scale threshold: count tops out at all-ones without wrapping
    configure(4'b0001, 4'b0001, 8'hFF);
    bus.ArmEn = 1'b1; tick();
    run_to_trigger(300, n);
    check("t6_max_latency", 32'(n), 32'd259);
    tick(); tick();
    check("t6_max_cnt", 32'(bus.MatchCnt), 32'hFF);
    bus.TrigAck = 1'b1; bus.ArmEn = 1'b0; tick();
    bus.TrigAck = 1'b0;

    // Random phase against the model
    for (int i = 0; i < 3000; i++) begin
      bus.Qin          = 1'($urandom);
      bus.ArmEn        = ($urandom_range(9, 0) != 0);
      bus.TrigAck      = ($urandom_range(4, 0) == 0);
      bus.CfgValid     = ($urandom_range(9, 0) == 0);
      bus.CfgPattern   = HIST_W'($urandom);
      bus.CfgMask      = HIST_W'($urandom);
      bus.CfgThreshold = CNT_W'($urandom_range(4, 0));
      rst              = ($urandom_range(199, 0) == 0);
      tick();
    end
    rst = 1'b0; bus.CfgValid = 1'b0; bus.TrigAck = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
